// File: rtl/swdisp_pkg.sv
// Shared board-display definitions: active-low segment glyphs {dp,g,f,e,d,c,b,a}
// and the 4-bit value to segment-byte encoder.
package swdisp_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [7:0] seg_t;

    localparam seg_t SEG_0     = 8'b1100_0000;
    localparam seg_t SEG_1     = 8'b1111_1001;
    localparam seg_t SEG_2     = 8'b1010_0100;
    localparam seg_t SEG_3     = 8'b1011_0000;
    localparam seg_t SEG_4     = 8'b1001_1001;
    localparam seg_t SEG_5     = 8'b1001_0010;
    localparam seg_t SEG_6     = 8'b1000_0010;
    localparam seg_t SEG_7     = 8'b1111_1000;
    localparam seg_t SEG_8     = 8'b1000_0000;
    localparam seg_t SEG_9     = 8'b1001_0000;
    localparam seg_t SEG_BLANK = 8'b1111_1111;

    function automatic seg_t seg_encode(input bcd_t value);
        seg_t seg;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch channel: 2-flop synchroniser, qualification counter and stable level,
// with a one-cycle pulse on each accepted 0->1 transition.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_stable;
    logic          r_rise;
    logic [CW-1:0] r_count;

    // Any cycle where sync agrees with stable restarts qualification, so bounces never accumulate.
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            if (r_sync == r_stable) begin
                r_count <= '0;
            end else if (r_count == TERMINAL) begin
                r_stable <= r_sync;
                r_rise   <= r_sync;
                r_count  <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign stable = r_stable;
    assign rise   = r_rise;

endmodule

// File: rtl/switch_display_debounced.sv
// Debounced switch display: per-channel LED and active-low digit, all registered.
// Define SWDISP_TOGGLE_COUNT_EN to show a per-channel BCD count of accepted rises on the digits.
module switch_display_debounced
    import swdisp_pkg::*;
#(
    parameter int unsigned CHANNELS        = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic [0:CHANNELS-1]     SW,
    output logic [0:CHANNELS-1]     LEDR,
    output logic [0:8*CHANNELS-1]   HEX
);

    logic [0:CHANNELS-1] w_stable;
    logic [0:CHANNELS-1] w_rise;
    logic [0:CHANNELS-1] r_ledr;

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            r_ledr <= '0;
        end else begin
            r_ledr <= w_stable;
        end
    end

    assign LEDR = r_ledr;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        seg_t r_digit;

        switch_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .CLOCK_50(CLOCK_50),
            .RESET_N (RESET_N),
            .raw     (SW[i]),
            .stable  (w_stable[i]),
            .rise    (w_rise[i])
        );

`ifdef SWDISP_TOGGLE_COUNT_EN
        bcd_t r_count;
        bcd_t w_count_next;

        always_comb begin
            w_count_next = r_count;
            if (w_rise[i]) begin
                w_count_next = (r_count == 4'd9) ? '0 : r_count + 4'd1;
            end
        end

        // Digit encodes the next count so it lands on the same edge as LEDR.
        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                r_count <= '0;
                r_digit <= SEG_0;
            end else begin
                r_count <= w_count_next;
                r_digit <= seg_encode(w_count_next);
            end
        end
`else
        always_ff @(posedge CLOCK_50) begin
            if (!RESET_N) begin
                r_digit <= SEG_0;
            end else begin
                r_digit <= w_stable[i] ? SEG_1 : SEG_0;
            end
        end
`endif

        assign HEX[8*i +: 8] = r_digit;
    end

endmodule

// File: doc/switch_display_debounced.md
# switch_display_debounced

Parametrised switch-status display for the DE-series board top level. It samples up to six slide switches, synchronises and debounces each one, and drives one LED and one active-low 7-segment digit per switch. It replaces the direct switch-to-LED wiring with registered, glitch-free outputs. An optional build adds a per-channel toggle counter shown on the digits.

## Interface
Parameters:
- CHANNELS, 6, number of switch/LED/digit channels; legal range 1..6.
- DEBOUNCE_CYCLES, 500000, number of consecutive clock cycles a synchronised level must differ from the stable level before it is accepted (10 ms at 50 MHz); legal minimum 2.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- SW  input  [0:CHANNELS-1]  raw asynchronous switch levels; 1 = up.
- LEDR  output  [0:CHANNELS-1]  debounced switch state; 1 = lit.
- HEX  output  [0:8*CHANNELS-1]  digit for channel i occupies bits [8i : 8i+7].
  - Bit 8i is the decimal point; bits 8i+1..8i+7 are segments g..a.
  - All segments are active-low; decimal point is always 1 (off).

## Operation
- Per channel, an independent pipeline: 2-flop synchroniser → debounce counter → stable level → output registers.
- Debounce counter rules, each cycle:
  - sync == stable: counter cleared to 0.
  - sync != stable and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync; counter cleared.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps; it is always cleared at the terminal count.
- Glitch handling: a bounce shorter than DEBOUNCE_CYCLES returns sync to stable, which clears the counter. Stable does not change.
- LEDR[i] is a registered copy of stable[i].
- HEX digit for channel i is registered. Without the macro it shows:
  - stable = 1: 8'b11111001 (glyph "1").
  - stable = 0: 8'b11000000 (glyph "0").
- Channels never interact; simultaneous transitions on any set of channels are handled independently in the same cycle.
- Reset values while RESET_N = 0 at a clock edge:
  - Synchroniser flops, stable, counters: 0.
  - LEDR: all 0.
  - Every digit: 8'b11000000.
- Reset mid-debounce abandons the partial count. After release the channel restarts from stable = 0.

## Timing
- Latency: SW[i] changes before edge t and is then held. LEDR[i] and the digit update at edge t+DEBOUNCE_CYCLES+2 and are visible after it. That is 2 synchroniser cycles, DEBOUNCE_CYCLES qualification cycles, and 1 output register cycle, counted so that the first qualifying count is edge t+2.
- A level held for DEBOUNCE_CYCLES-1 synchronised cycles is rejected.
- Outputs change only on clock edges; no combinational path from SW to any output.
- RESET_N is sampled through no synchroniser; it is assumed synchronous to CLOCK_50.

## Configuration
- SWDISP_TOGGLE_COUNT_EN defined:
  - Each channel adds a 4-bit BCD counter that increments on every accepted 0→1 transition of stable.
  - The counter wraps 9→0.
  - The digit shows the counter value (0–9 glyphs) instead of the switch state.
  - LEDR is unchanged.
  - The counter resets to 0.
  - An accepted rise and reset in the same cycle: reset wins.
- Macro undefined: no counters exist; digits show 0/1 as above.

## Structure
- Package swdisp_pkg holds:
  - the 8-bit segment constants for glyphs 0–9;
  - a function mapping 4-bit value → segment byte, shared with other board-display blocks.
- Natural sub-module: switch_debouncer, with parameter DEBOUNCE_CYCLES and ports CLOCK_50, RESET_N, raw, stable, rise.
  - rise is a one-cycle pulse on an accepted 0→1 transition.
  - The top level instantiates CHANNELS copies with a generate loop and owns the output registers and optional counters.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and CHANNELS = 6.
- Reset: hold RESET_N = 0 for 3 cycles with SW = 6'b111111 → LEDR = 0, every digit = 8'b11000000 throughout. After release, LEDR = 6'b111111 exactly 6 cycles later.
- Clean toggle: raise SW[2] and hold → LEDR[2] = 1 and digit 2 = 8'b11111001 after exactly 6 edges; no earlier change.
- Bounce rejection: pulse SW[0] high for 3 cycles, low for 2, high for 3, then low → LEDR[0] and digit 0 never change.
- Simultaneous channels: raise SW[0], SW[5]; two cycles later raise SW[3] → LEDR[0], LEDR[5] rise at the same edge; LEDR[3] rises 2 edges later.
- Reset mid-debounce: raise SW[1], assert RESET_N = 0 for one cycle at edge 4 → full 6-cycle latency restarts from the reset release.
- With SWDISP_TOGGLE_COUNT_EN: perform 11 clean up/down toggles of SW[4] → digit 4 steps 1..9, 0, 1 (final 8'b11111001); other digits stay 8'b11000000.
